uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Recovers 8N1 frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit) from the asynchronous serial line rx_in.
- Uses an oversampling tick from the shared baud generator and presents each byte as a parallel word with a one-cycle valid strobe.
- Flags stop-bit (framing) errors.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, >=4.
- DATA_BITS, 8, data bits per frame, 5..8.
- SYNC_STAGES, 2, synchronizer flops on rx_in, >=2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  single-cycle pulse at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clk and rst are decided; rst is synchronous, active-high.
  - On rst: rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, tick counter=0, bit index=0, shift register=0, synchronizer flops=1 (idle level).
  - rst asserted mid-frame aborts the frame with no valid or error pulse.
- Synchronizer: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counters:
  - tick_cnt has width clog2(OVERSAMPLE). It increments only on cycles with baud_tick=1 and is cleared on every state transition.
  - bit_idx has width clog2(DATA_BITS)+1.
- States:
  - IDLE: rx_busy=0. When rx_s==0, go to START with tick_cnt=0. baud_tick is not required for this transition.
  - START: on baud_tick with tick_cnt==OVERSAMPLE/2-1 (start-bit midpoint):
    - rx_s==0: go to DATA, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no pulse.
  - DATA: on baud_tick with tick_cnt==OVERSAMPLE-1 (data-bit midpoint):
    - Shift rx_s into the MSB of the shift register (right shift, so LSB-first reception lands correctly) and increment bit_idx.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on baud_tick with tick_cnt==OVERSAMPLE-1:
    - rx_s==1: rx_data <= shift register, rx_valid=1 for exactly that cycle, go to IDLE.
    - rx_s==0: frame_err=1 for that cycle, rx_data unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- Timing:
  - Return to IDLE at the stop-bit midpoint allows back-to-back frames.
  - The next start edge is detected on the first rx_s==0 cycle in IDLE.
- Exclusivity: rx_valid and frame_err are never high in the same cycle.
- Ticks outside the frame: baud_tick while in IDLE or BREAK has no effect.
- No handshaking: the consumer must capture rx_data on rx_valid. rx_data holds until the next valid frame.
- Latency: rx_valid asserts SYNC_STAGES + ~(DATA_BITS+1.5)*OVERSAMPLE ticks after the falling edge of rx_in.

Test Plan:
- Bench defaults: OVERSAMPLE=16, baud_tick every 4 clk, so 1 bit = 64 clk.
- Send 0xA5, stop=1 -> exactly one rx_valid pulse with rx_data=0xA5; frame_err stays 0; rx_busy high from about 3 clk after the start edge until the pulse.
- Two back-to-back frames 0x00 then 0xFF, with no idle gap between them -> two rx_valid pulses, rx_data=0x00 then 0xFF, both accepted.
- Send 0x3C with stop bit forced 0, then hold the line low for 3 bit times, then release -> one frame_err pulse, no rx_valid, rx_data keeps its previous value. There is no second start until the line goes high and then falls again.
- Low glitch on rx_in of 3 bit-ticks (12 clk) from idle -> START is entered, then IDLE is re-entered at the midpoint check; no pulses; a following frame 0x5A is received correctly.
- Assert rst for 1 clk during data bit 4 of frame 0x81 -> all outputs are 0 the next cycle, no pulse; a subsequent frame 0x81 yields rx_data=0x81.
- Parameter check: DATA_BITS=7, send 0x55 (7 bits) -> rx_valid with rx_data=7'h55; the rx_valid pulse arrives 16 ticks earlier than in the 8-bit case.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1-style frame recovery with framing-error detection.
// Expects baud_tick from the shared baud generator at OVERSAMPLE x the bit rate.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d;
  logic                   ferr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_q == MID_TICK) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            // Right shift so the first (LSB) bit ends up at bit 0 after the last sample.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      BREAK: begin
        // A line held low must return high before another start bit can be accepted.
        tick_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level expectation queue plus directed checks.
module tb_uart_rx;

  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int SS      = 2;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OS * TDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_in2 = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_busy;
  logic [6:0] rx_data2;
  logic       rx_valid2, frame_err2, rx_busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(7), .SYNC_STAGES(SS)) dut7 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2), .rx_busy(rx_busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ticks are sampled by the DUT on posedges whose index is a multiple of TDIV.
  initial forever begin
    @(posedge clk);
    #1;
    baud_tick = ((cyc % TDIV) == TDIV - 1);
  end

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev_c;
  logic [7:0] model_data = 8'h00;
  int         busy_lo = -1;
  int         busy_hi = -2;
  bit         chk_en = 1'b0;
  bit         rst_pend = 1'b0;
  int         v1_cnt = 0, last_v1 = 0, ferr_cnt = 0;
  int         v2_cnt = 0, last_v2 = 0, f2_cnt = 0;
  int         last_p = 0;

  // Pulse cycle from the frame rules: sync delay, immediate IDLE->START, then
  // OS/2 ticks to the start midpoint, OS per data bit and OS for the stop bit.
  function automatic int exp_pulse_cyc(input int p, input int nbits);
    int t_start, t1, n;
    t_start = p + SS + 1;
    t1 = ((t_start / TDIV) + 1) * TDIV;
    n = OS / 2 + nbits * OS + OS;
    return t1 + (n - 1) * TDIV;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align;
    while ((cyc % TDIV) != 0) wait_clk(1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit expect_ev);
    ev_t ev;
    int  p;
    align();
    p = cyc;
    last_p = p;
    if (expect_ev) begin
      ev.is_err = !stop;
      ev.data   = data;
      ev.cyc    = exp_pulse_cyc(p, DB);
      exp_q.push_back(ev);
      busy_lo = p + SS + 3;
      busy_hi = ev.cyc - 2;
    end
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < DB; i++) begin
      rx_in = data[i];
      wait_clk(BIT_CLK);
    end
    rx_in = stop;
    wait_clk(BIT_CLK);
  endtask

  task automatic send7(input logic [6:0] data);
    align();
    last_p = cyc;
    rx_in2 = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 7; i++) begin
      rx_in2 = data[i];
      wait_clk(BIT_CLK);
    end
    rx_in2 = 1'b1;
    wait_clk(BIT_CLK);
  endtask

  always @(negedge clk) begin
    if (rx_valid2) begin
      v2_cnt++;
      last_v2 = cyc;
    end
    if (frame_err2) f2_cnt++;
  end

  // Per-cycle comparison of the 8-bit instance against the expectation queue.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rx_valid) begin
        v1_cnt++;
        last_v1 = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (rst_pend) begin
        rst_pend = 1'b0;
        model_data = 8'h00;
        exp_q.delete();
        busy_lo = -1;
        busy_hi = -2;
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", rx_busy, 0);
      end else begin
        check("pulse_excl", rx_valid & frame_err, 0);
        if (rx_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {rx_valid, frame_err}, 0);
          end else begin
            ev_c = exp_q.pop_front();
            check("pulse_kind_ferr", frame_err, ev_c.is_err);
            check_range("pulse_cycle", cyc, ev_c.cyc - 2, ev_c.cyc + 2);
            if (rx_valid && !ev_c.is_err) model_data = ev_c.data;
          end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 2) begin
          checks++;
          errors++;
          $display("FAIL missing_pulse: actual=none required=pulse by cyc %0d (cyc %0d)",
                   exp_q[0].cyc + 2, cyc);
          void'(exp_q.pop_front());
        end
        if (cyc >= busy_lo && cyc <= busy_hi) check("busy_in_frame", rx_busy, 1);
      end
      check("rx_data_hold", rx_data, model_data);
      if (rst) rst_pend = 1'b1;
    end
  end

  initial begin
    int p, lat8, lat7;
    logic [7:0] b81;
    b81 = 8'h81;

    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    check("reset_rx_data", rx_data, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_rx_data7", rx_data2, 0);
    chk_en = 1'b1;
    wait_clk(20);

    send_frame(8'hA5, 1'b1, 1'b1);
    wait_clk(40);
    check("a5_data", rx_data, 8'hA5);
    check("a5_busy_after", rx_busy, 0);
    check("a5_valid_count", v1_cnt, 1);
    lat8 = last_v1 - last_p;
    check_range("a5_latency", lat8, 606, 610);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_clk(40);
    check("b2b_data", rx_data, 8'hFF);
    check("b2b_valid_count", v1_cnt, 3);

    send_frame(8'h3C, 1'b0, 1'b1);
    wait_clk(3 * BIT_CLK);
    check("break_busy_held", rx_busy, 1);
    check("break_ferr_count", ferr_cnt, 1);
    rx_in = 1'b1;
    wait_clk(100);
    check("break_busy_after", rx_busy, 0);
    check("break_data_kept", rx_data, 8'hFF);
    check("break_no_valid", v1_cnt, 3);

    align();
    p = cyc;
    rx_in = 1'b0;
    wait_clk(12);
    rx_in = 1'b1;
    wait_clk(8);
    check("glitch_busy_start", rx_busy, 1);
    wait_clk(60);
    check("glitch_busy_idle", rx_busy, 0);
    check("glitch_no_pulse", v1_cnt + ferr_cnt, 4);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_clk(40);
    check("after_glitch_data", rx_data, 8'h5A);
    check("after_glitch_count", v1_cnt, 4);

    align();
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_in = b81[i];
      wait_clk(BIT_CLK);
    end
    rx_in = b81[4];
    wait_clk(BIT_CLK / 2);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    rx_in = 1'b1;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", rx_busy, 0);
    wait_clk(100);
    check("midrst_no_pulse", v1_cnt, 4);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_clk(40);
    check("after_rst_data", rx_data, 8'h81);
    check("after_rst_count", v1_cnt, 5);

    send7(7'h55);
    wait_clk(40);
    check("db7_valid_count", v2_cnt, 1);
    check("db7_data", rx_data2, 7'h55);
    check("db7_no_ferr", f2_cnt, 0);
    lat7 = last_v2 - last_p;
    check_range("db7_latency", lat7, 542, 546);
    check("db7_vs_db8_latency", lat8 - lat7, 16 * TDIV);

    wait_clk(20);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
